// File: rtl/match_sequencer.sv
// match_sequencer: match-level controller sequencing IDLE/COUNTDOWN/PLAY/GAME_OVER,
// detecting blast-zone KOs, respawning players through their physics coprocessors,
// tracking stocks and declaring the winner.
//
// Ports:
//   clock                        master clock
//   reset                        asynchronous, active-low
//   start                        start button (level); the FSM acts on its rising edge
//   position_p1/p2 [31:0]        {x[31:16], y[15:0]}, both signed
//   phys_reset_p1/p2             active-high reset to each coprocessor
//   freeze_p1/p2                 drives each coprocessor's freeze_in
//   attack_en_p1/p2              high while the player can receive hits
//   stocks_p1/p2 [2:0]           remaining stocks
//   phase [1:0]                  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 GAME_OVER
//   winner [1:0]                 00 none, 01 P1, 10 P2, 11 draw
//
// Optional feature: define INVINCIBLE_EN to add a SHIELD state after FROZEN in
// which the player moves but cannot be hit for INVINC_CYCLES clocks.
module match_sequencer #(
    parameter int STOCKS        = 3,
    parameter int COUNT_CYCLES  = 50000000,
    parameter int RESET_CYCLES  = 4,
    parameter int FREEZE_CYCLES = 25000000,
    parameter int INVINC_CYCLES = 50000000,
    parameter int BLAST_L       = -32,
    parameter int BLAST_R       = 672,
    parameter int BLAST_B       = -32,
    parameter int BLAST_T       = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] position_p1,
    input  logic [31:0] position_p2,
    output logic        phys_reset_p1,
    output logic        phys_reset_p2,
    output logic        freeze_p1,
    output logic        freeze_p2,
    output logic        attack_en_p1,
    output logic        attack_en_p2,
    output logic [2:0]  stocks_p1,
    output logic [2:0]  stocks_p2,
    output logic [1:0]  phase,
    output logic [1:0]  winner
);
    localparam int M0 = COUNT_CYCLES > RESET_CYCLES ? COUNT_CYCLES : RESET_CYCLES;
    localparam int M1 = FREEZE_CYCLES > INVINC_CYCLES ? FREEZE_CYCLES : INVINC_CYCLES;
    localparam int MAXC = M0 > M1 ? M0 : M1;
    localparam int CB = $clog2(MAXC + 1);
    localparam int CW = CB < 26 ? 26 : CB;
    localparam logic signed [15:0] BL = 16'(BLAST_L);
    localparam logic signed [15:0] BR = 16'(BLAST_R);
    localparam logic signed [15:0] BB = 16'(BLAST_B);
    localparam logic signed [15:0] BT = 16'(BLAST_T);

    typedef enum logic [1:0] {IDLE = 2'b00, COUNTDOWN = 2'b01, PLAY = 2'b10, GAME_OVER = 2'b11} phase_t;
    typedef enum logic [1:0] {ALIVE, KO, FROZEN, SHIELD} pstate_t;

    phase_t        phase_q, phase_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic          start_q;
    logic [1:0]    win_q, win_d;
    pstate_t       ps_q [2];
    pstate_t       ps_d [2];
    logic [CW-1:0] pc_q [2];
    logic [CW-1:0] pc_d [2];
    logic [2:0]    stk_q [2];
    logic [2:0]    stk_d [2];
    logic          pr_q [2];
    logic          pr_d [2];
    logic          fr_q [2];
    logic          fr_d [2];
    logic          at_q [2];
    logic          at_d [2];
    logic [31:0]   pos [2];
    logic          oob [2];
    logic          start_rise;

    assign pos[0] = position_p1;
    assign pos[1] = position_p2;
    assign start_rise = start & ~start_q;

    always_comb begin
        phase_d = phase_q;
        mcnt_d  = mcnt_q;
        win_d   = win_q;
        for (int i = 0; i < 2; i++) begin
            oob[i] = $signed(pos[i][31:16]) < BL || $signed(pos[i][31:16]) > BR ||
                     $signed(pos[i][15:0]) < BB || $signed(pos[i][15:0]) > BT;
            stk_d[i] = stk_q[i];
            ps_d[i]  = ps_q[i];
            pc_d[i]  = pc_q[i];
            if (phase_q == PLAY) begin
                // SHIELD only blocks hits, so a blast-zone exit there still costs a stock
                if (oob[i] && (ps_q[i] == ALIVE || ps_q[i] == SHIELD)) begin
                    stk_d[i] = stk_q[i] == 3'd0 ? 3'd0 : stk_q[i] - 3'd1;
                    ps_d[i]  = KO;
                    pc_d[i]  = CW'(RESET_CYCLES - 1);
                end else if (ps_q[i] != ALIVE && pc_q[i] != '0) begin
                    pc_d[i] = pc_q[i] - 1'b1;
                end else if (ps_q[i] == KO) begin
                    ps_d[i] = FROZEN;
                    pc_d[i] = CW'(FREEZE_CYCLES - 1);
                end else if (ps_q[i] == FROZEN) begin
`ifdef INVINCIBLE_EN
                    ps_d[i] = SHIELD;
                    pc_d[i] = CW'(INVINC_CYCLES - 1);
`else
                    ps_d[i] = ALIVE;
`endif
                end else if (ps_q[i] == SHIELD) begin
                    ps_d[i] = ALIVE;
                end
            end
        end
        case (phase_q)
            IDLE: begin
                if (start_rise) begin
                    phase_d = COUNTDOWN;
                    mcnt_d  = CW'(COUNT_CYCLES - 1);
                end
            end
            COUNTDOWN: begin
                if (mcnt_q == '0) phase_d = PLAY;
                else mcnt_d = mcnt_q - 1'b1;
            end
            PLAY: begin
                // game ends on the same edge as the final KO; bit1 = P1 out, bit0 = P2 out
                if (stk_d[0] == 3'd0 || stk_d[1] == 3'd0) begin
                    phase_d = GAME_OVER;
                    win_d   = {stk_d[0] == 3'd0, stk_d[1] == 3'd0};
                end
            end
            default: begin
                if (start_rise) begin
                    phase_d  = IDLE;
                    win_d    = 2'b00;
                    stk_d[0] = 3'(STOCKS);
                    stk_d[1] = 3'(STOCKS);
                end
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            // outside PLAY the per-player FSM parks in ALIVE, which also drops a final KO
            if (phase_d != PLAY) begin
                ps_d[i] = ALIVE;
                pc_d[i] = '0;
            end
            pr_d[i] = phase_d == IDLE || (phase_d == PLAY && ps_d[i] == KO);
            fr_d[i] = phase_d != PLAY || ps_d[i] == KO || ps_d[i] == FROZEN;
            at_d[i] = phase_d == PLAY && ps_d[i] == ALIVE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= IDLE;
            mcnt_q  <= '0;
            start_q <= 1'b0;
            win_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                ps_q[i]  <= ALIVE;
                pc_q[i]  <= '0;
                stk_q[i] <= 3'(STOCKS);
                pr_q[i]  <= 1'b1;
                fr_q[i]  <= 1'b1;
                at_q[i]  <= 1'b0;
            end
        end else begin
            phase_q <= phase_d;
            mcnt_q  <= mcnt_d;
            start_q <= start;
            win_q   <= win_d;
            for (int i = 0; i < 2; i++) begin
                ps_q[i]  <= ps_d[i];
                pc_q[i]  <= pc_d[i];
                stk_q[i] <= stk_d[i];
                pr_q[i]  <= pr_d[i];
                fr_q[i]  <= fr_d[i];
                at_q[i]  <= at_d[i];
            end
        end
    end

    assign phase         = phase_q;
    assign winner        = win_q;
    assign stocks_p1     = stk_q[0];
    assign stocks_p2     = stk_q[1];
    assign phys_reset_p1 = pr_q[0];
    assign phys_reset_p2 = pr_q[1];
    assign freeze_p1     = fr_q[0];
    assign freeze_p2     = fr_q[1];
    assign attack_en_p1  = at_q[0];
    assign attack_en_p2  = at_q[1];
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: scoreboard bench for match_sequencer against a timer-based reference model.
module tb_match_sequencer;
    localparam int R = 4;
    localparam int F = 8;
`ifdef INVINCIBLE_EN
    localparam int I = 6;
`else
    localparam int I = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] position_p1 = 32'd0;
    logic [31:0] position_p2 = 32'd0;
    logic        phys_reset_p1, phys_reset_p2, freeze_p1, freeze_p2, attack_en_p1, attack_en_p2;
    logic [2:0]  stocks_p1, stocks_p2;
    logic [1:0]  phase, winner;

    match_sequencer #(
        .STOCKS(2), .COUNT_CYCLES(10), .RESET_CYCLES(R), .FREEZE_CYCLES(F), .INVINC_CYCLES(6)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .position_p1(position_p1), .position_p2(position_p2),
        .phys_reset_p1(phys_reset_p1), .phys_reset_p2(phys_reset_p2),
        .freeze_p1(freeze_p1), .freeze_p2(freeze_p2),
        .attack_en_p1(attack_en_p1), .attack_en_p2(attack_en_p2),
        .stocks_p1(stocks_p1), .stocks_p2(stocks_p2),
        .phase(phase), .winner(winner)
    );

    always #5 clock = ~clock;

    logic [15:0] act;
    assign act = {phase, winner, stocks_p1, stocks_p2, phys_reset_p1, phys_reset_p2,
                  freeze_p1, freeze_p2, attack_en_p1, attack_en_p2};
    localparam logic [15:0] RST_V = {2'b00, 2'b00, 3'd2, 3'd2, 2'b11, 2'b11, 2'b00};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] exp_q [$];

    // Reference model: a match phase, a countdown of remaining clocks, and per player
    // the number of clocks since the last KO (-1 when fully alive).
    int mph, cd, sprev;
    int stk [2];
    int age [2];
    logic [1:0] mwin;

    function automatic bit out_of_bounds(logic [31:0] p);
        int x, y;
        x = int'($signed(p[31:16]));
        y = int'($signed(p[15:0]));
        return x < -32 || x > 672 || y < -32 || y > 512;
    endfunction

    function automatic logic [15:0] expected();
        logic [1:0] pr, fr, at;
        for (int p = 0; p < 2; p++) begin
            pr[1-p] = mph == 0 || (mph == 2 && age[p] >= 0 && age[p] < R);
            fr[1-p] = mph != 2 || (age[p] >= 0 && age[p] < R + F);
            at[1-p] = mph == 2 && age[p] < 0;
        end
        return {2'(mph), mwin, 3'(stk[0]), 3'(stk[1]), pr, fr, at};
    endfunction

    always @(posedge clock) begin
        bit rise;
        bit ko [2];
        cyc++;
        if (!reset) begin
            mph = 0; cd = 0; sprev = 0; mwin = 2'b00;
            stk[0] = 2; stk[1] = 2; age[0] = -1; age[1] = -1;
        end else begin
            rise = start && sprev == 0;
            sprev = int'(start);
            if (mph == 0) begin
                if (rise) begin mph = 1; cd = 10; end
            end else if (mph == 1) begin
                cd--;
                if (cd == 0) mph = 2;
            end else if (mph == 2) begin
                ko[0] = out_of_bounds(position_p1) && (age[0] < 0 || age[0] >= R + F);
                ko[1] = out_of_bounds(position_p2) && (age[1] < 0 || age[1] >= R + F);
                for (int p = 0; p < 2; p++) begin
                    if (ko[p]) begin
                        stk[p] = stk[p] > 0 ? stk[p] - 1 : 0;
                        age[p] = 0;
                    end else if (age[p] >= 0) begin
                        age[p]++;
                        if (age[p] == R + F + I) age[p] = -1;
                    end
                end
                if (stk[0] == 0 || stk[1] == 0) begin
                    mph = 3;
                    mwin = {stk[0] == 0, stk[1] == 0};
                    age[0] = -1; age[1] = -1;
                end
            end else if (rise) begin
                mph = 0; mwin = 2'b00; stk[0] = 2; stk[1] = 2;
            end
        end
        exp_q.push_back(expected());
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %h expected %h (phase,winner,stk1,stk2,rst,frz,atk)",
                         cyc, act, e);
            end
        end
    end

    function automatic logic [31:0] pos(int x, int y);
        return {16'(x), 16'(y)};
    endfunction

    task automatic step(input logic [31:0] p1, input logic [31:0] p2, input logic s);
        @(negedge clock);
        #1;
        position_p1 = p1;
        position_p2 = p2;
        start = s;
    endtask

    task automatic idle(input int n);
        repeat (n) step(pos(100, 100), pos(200, 100), 1'b0);
    endtask

    task automatic press_start();
        step(pos(100, 100), pos(200, 100), 1'b1);
        idle(1);
    endtask

    function automatic logic [31:0] rand_pos();
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 5))
                0: return pos(-33, 100);
                1: return pos(673, 100);
                2: return pos(100, -33);
                3: return pos(100, 513);
                4: return pos(-32768, 0);
                default: return pos(0, 32767);
            endcase
        end
        return pos(int'($urandom_range(0, 704)) - 32, int'($urandom_range(0, 544)) - 32);
    endfunction

    initial begin
        idle(3);
        #1 reset = 1'b1;
        idle(2);
        press_start();
        idle(13);
        step(pos(-33, 100), pos(200, 100), 1'b0);
        idle(16);
        step(pos(-32, 100), pos(200, 100), 1'b0);
        step(pos(100, 512), pos(200, 100), 1'b0);
        step(pos(672, -32), pos(200, 100), 1'b0);
        step(pos(100, 513), pos(200, 100), 1'b0);
        idle(3);
        press_start();
        press_start();
        idle(13);
        step(pos(-33, 100), pos(200, 100), 1'b0);
        idle(16);
        step(pos(100, 100), pos(673, 100), 1'b0);
        idle(16);
        step(pos(100, -33), pos(200, 513), 1'b0);
        idle(3);
        press_start();
        press_start();
        idle(13);
        step(pos(-33, 100), pos(200, 100), 1'b0);
        idle(2);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (act !== RST_V) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", act, RST_V);
        end
        idle(3);
        #1 reset = 1'b1;
        idle(2);
        for (int n = 0; n < 3000; n++)
            step(rand_pos(), rand_pos(), $urandom_range(0, 19) == 0);
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
